// File: rtl/altmem_pkg.sv
// Shared types and helpers for the byte-enable simple-dual-port RAM.
// Optional build macro: ALTMEM_RDW_BYPASS_EN (used by alt_mem_be_pipe).
package altmem_pkg;

    // Sweep-then-serve controller states
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } altmem_state_t;

    // Widest word the byte-merge helper can handle
    localparam int ALTMEM_MAX_DW = 1024;

    // Number of byte-enable lanes in a word
    function automatic int nbe(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    // Per-lane merge: lanes with be set take new_w, the rest keep old_w.
    // Operands are zero-extended to ALTMEM_MAX_DW by the caller.
    function automatic logic [ALTMEM_MAX_DW-1:0] merge_be(
        input logic [ALTMEM_MAX_DW-1:0] old_w,
        input logic [ALTMEM_MAX_DW-1:0] new_w,
        input logic [ALTMEM_MAX_DW-1:0] be,
        input int                       byte_width
    );
        logic [ALTMEM_MAX_DW-1:0] res;
        res = old_w;
        for (int i = 0; i < ALTMEM_MAX_DW; i++) begin
            if (be[i / byte_width]) begin
                res[i] = new_w[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/altmem_array.sv
// Behavioural storage for alt_mem_be_pipe: one lane-wide array per byte
// lane so each lane has its own write enable; registered read that returns
// the pre-write contents on a same-cycle collision.
module altmem_array
    import altmem_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_WIDTH = 8,
    parameter int MEMSIZE    = 512,
    parameter int IDX_WIDTH  = 9,
    localparam int NBE       = nbe(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic [NBE-1:0]        we,
    input  logic [IDX_WIDTH-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [IDX_WIDTH-1:0]  raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    generate
        for (genvar gi = 0; gi < NBE; gi++) begin : g_lane
            logic [BYTE_WIDTH-1:0] mem_lane [MEMSIZE];
            logic [BYTE_WIDTH-1:0] rd_lane_q;

            // Lane write, gated by this lane's enable
            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem_lane[waddr] <= wdata[gi*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end

            // Registered read; holds when no read is issued
            always_ff @(posedge clk) begin
                if (re) begin
                    rd_lane_q <= mem_lane[raddr];
                end
            end

            assign rdata[gi*BYTE_WIDTH +: BYTE_WIDTH] = rd_lane_q;
        end
    endgenerate

endmodule

// File: rtl/alt_mem_be_pipe.sv
// Simple-dual-port RAM with byte enables, 1- or 2-cycle read latency,
// read-valid strobe and an optional zeroing sweep after reset.
// Build macro ALTMEM_RDW_BYPASS_EN: when defined, a read and write to the
// same address in the same cycle return the byte-merged new word; when
// undefined, such a read returns the old contents.
module alt_mem_be_pipe
    import altmem_pkg::*;
#(
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 64,
    parameter int BYTE_WIDTH   = 8,
    parameter int MEMSIZE      = 512,
    parameter int OUT_REG      = 0,
    parameter int CLEAR_ON_RST = 1,
    localparam int NBE         = nbe(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    output logic                  RDY,
    input  logic                  WEN,
    input  logic [ADDR_WIDTH-1:0] ADDRW,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic [NBE-1:0]        BE,
    input  logic                  REN,
    input  logic [ADDR_WIDTH-1:0] ADDRR,
    output logic [DATA_WIDTH-1:0] DO,
    output logic                  DO_VALID
);

    localparam int IW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam logic [ADDR_WIDTH:0] MEMSIZE_W = (ADDR_WIDTH + 1)'(MEMSIZE);
    localparam logic [IW-1:0]       LAST_IDX  = IW'(MEMSIZE - 1);

    generate
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_lanes
            $error("alt_mem_be_pipe: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if (MEMSIZE < 1 || MEMSIZE > (1 << ADDR_WIDTH)) begin : g_bad_size
            $error("alt_mem_be_pipe: MEMSIZE must be within 1..2**ADDR_WIDTH");
        end
        if (DATA_WIDTH > ALTMEM_MAX_DW) begin : g_bad_width
            $error("alt_mem_be_pipe: DATA_WIDTH exceeds ALTMEM_MAX_DW");
        end
    endgenerate

    altmem_state_t         state_q, state_d;
    logic [IW-1:0]         cnt_q, cnt_d;
    logic                  clearing;
    logic                  w_in_range, r_in_range;
    logic                  wr_acc, rd_acc;
    logic [NBE-1:0]        arr_we;
    logic [IW-1:0]         arr_waddr;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic                  v1_q;
    logic                  zero_q;
    logic [DATA_WIDTH-1:0] rd_word;

    // Controller state and sweep counter; reset restarts the sweep
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= (CLEAR_ON_RST != 0) ? CLEAR : RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: walk the sweep to the last real word, then serve requests
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
                state_d = RUN;
                cnt_d   = '0;
            end
        end
    end

    assign RDY        = (state_q == RUN) && !RST;
    assign clearing   = (state_q == CLEAR) && !RST;
    assign w_in_range = {1'b0, ADDRW} < MEMSIZE_W;
    assign r_in_range = {1'b0, ADDRR} < MEMSIZE_W;
    assign wr_acc     = RDY && WEN && w_in_range;
    assign rd_acc     = RDY && REN;

    // Sweep owns the write port while clearing; otherwise the user does
    assign arr_we    = clearing ? {NBE{1'b1}} : (wr_acc ? BE : '0);
    assign arr_waddr = clearing ? cnt_q : ADDRW[IW-1:0];
    assign arr_wdata = clearing ? '0 : DI;

    altmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH),
        .MEMSIZE    (MEMSIZE),
        .IDX_WIDTH  (IW)
    ) u_array (
        .clk   (CLK),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .re    (rd_acc && r_in_range),
        .raddr (ADDRR[IW-1:0]),
        .rdata (arr_rdata)
    );

    // First read stage: valid strobe plus force-zero for out-of-range/reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            v1_q   <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            v1_q <= rd_acc;
            if (rd_acc) begin
                zero_q <= !r_in_range;
            end
        end
    end

`ifdef ALTMEM_RDW_BYPASS_EN
    logic                  byp_hit_q;
    logic [DATA_WIDTH-1:0] byp_data_q;
    logic [NBE-1:0]        byp_be_q;

    // Capture a same-address write alongside the read so it can be merged
    always_ff @(posedge CLK) begin
        if (RST) begin
            byp_hit_q <= 1'b0;
        end else if (rd_acc) begin
            byp_hit_q  <= wr_acc && (ADDRW == ADDRR);
            byp_data_q <= DI;
            byp_be_q   <= BE;
        end
    end

    assign rd_word = zero_q    ? '0 :
                     byp_hit_q ? DATA_WIDTH'(merge_be(ALTMEM_MAX_DW'(arr_rdata),
                                                      ALTMEM_MAX_DW'(byp_data_q),
                                                      ALTMEM_MAX_DW'(byp_be_q),
                                                      BYTE_WIDTH))
                               : arr_rdata;
`else
    assign rd_word = zero_q ? '0 : arr_rdata;
`endif

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] do_q;
            logic                  valid_q;

            // Extra output stage; DO only moves when a read completes
            always_ff @(posedge CLK) begin
                if (RST) begin
                    do_q    <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= v1_q;
                    if (v1_q) begin
                        do_q <= rd_word;
                    end
                end
            end

            assign DO       = do_q;
            assign DO_VALID = valid_q;
        end else begin : g_out_direct
            assign DO       = rd_word;
            assign DO_VALID = v1_q;
        end
    endgenerate

endmodule
